dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory/IO port between the core load-store path (port 0) and a debug/DMA loader (port 1). It sits between the requesters and the synchronous data memory. It sequences each access through a fixed grant -> access -> response pipeline, and it arbitrates round-robin with an optional port-1 lock for bursts.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous data memory.
// Each access runs grant -> access -> response; port 1 may lock ownership across a burst.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_bmask,
    output logic                m0_gnt,
    output logic                m0_done,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_bmask,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_done,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_bmask,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int unsigned BW = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic                lock_q;
    logic                id_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BW-1:0]       bmask_q;
    logic                mem_req_q;
    logic [1:0]          gnt_q;
    logic [1:0]          done_q;

    logic                elig0;
    logic                elig1;
    logic                win_valid;
    logic                win_id;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BW-1:0]       sel_bmask;

    // A held lock hides port 0 entirely; on contention the port not granted last wins.
    always_comb begin
        elig0     = m0_req && !lock_q;
        elig1     = m1_req;
        win_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            win_id = ~last_grant_q;
        end else begin
            win_id = elig1;
        end
        sel_we    = win_id ? m1_we    : m0_we;
        sel_addr  = win_id ? m1_addr  : m0_addr;
        sel_wdata = win_id ? m1_wdata : m0_wdata;
        sel_bmask = win_id ? m1_bmask : m0_bmask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bmask_q      <= '0;
            mem_req_q    <= 1'b0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
        end else begin
            mem_req_q <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            unique case (state_q)
                StIdle, StResp: begin
                    if (!m1_req) begin
                        lock_q <= 1'b0;
                    end
                    if (win_valid) begin
                        state_q      <= StAccess;
                        last_grant_q <= win_id;
                        id_q         <= win_id;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        bmask_q      <= sel_bmask;
                        mem_req_q    <= 1'b1;
                        gnt_q        <= win_id ? 2'b10 : 2'b01;
                        if (win_id) begin
                            lock_q <= m1_lock;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                    done_q  <= id_q ? 2'b10 : 2'b01;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Captured fields are kept after the access, so gate them onto the bus only in ACCESS.
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & we_q;
    assign mem_addr  = mem_req_q ? addr_q  : '0;
    assign mem_wdata = mem_req_q ? wdata_q : '0;
    assign mem_bmask = mem_req_q ? bmask_q : '0;

    assign m0_gnt   = gnt_q[0];
    assign m1_gnt   = gnt_q[1];
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-schedule reference model and a word-addressed memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_bmask, m1_bmask;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic [31:0] mem_rdata;
    logic        busy;

    // Environment memory: 256 words, one-cycle read latency, with clear/poke hooks.
    logic [31:0] ram [256];
    logic        ram_clear, poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cyc = 0;
    int          next_arb, gnt_cyc, done_cyc, owner, lastg;
    bit          lock;
    logic        t_we;
    logic [15:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_bmask;
    logic [31:0] exp_rdata;
    bit          e_gnt0, e_gnt1, e_done0, e_done1, e_busy;
    logic [31:0] mm [int];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bmask(m0_bmask), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bmask(m1_bmask), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_done(m1_done),
        .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_bmask(mem_bmask), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (poke_en) begin
            ram[poke_idx] <= poke_data;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_bmask[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    function automatic logic [31:0] mm_read(input int a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction

    function automatic void model_reset();
        next_arb = cyc;
        gnt_cyc  = -10;
        done_cyc = -10;
        owner    = 0;
        lastg    = 1;
        lock     = 1'b0;
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    function automatic void model_edge();
        logic [31:0] m;
        bit          c0, c1;
        int          w;
        if (cyc == gnt_cyc) begin
            if (t_we) begin
                m = 32'h0;
                for (int b = 0; b < 4; b++) if (t_bmask[b]) m = m + (32'hFF << (8 * b));
                mm[int'(t_addr)] = (mm_read(int'(t_addr)) & ~m) | (t_wdata & m);
            end else begin
                exp_rdata = mm_read(int'(t_addr));
            end
        end
        if (cyc >= next_arb) begin
            c0 = m0_req && !lock;
            c1 = m1_req;
            w  = -1;
            if (c0 && c1) w = 1 - lastg;
            else if (c0)  w = 0;
            else if (c1)  w = 1;
            if (!m1_req) lock = 1'b0;
            if (w >= 0) begin
                owner    = w;
                lastg    = w;
                t_we     = (w == 1) ? m1_we    : m0_we;
                t_addr   = (w == 1) ? m1_addr  : m0_addr;
                t_wdata  = (w == 1) ? m1_wdata : m0_wdata;
                t_bmask  = (w == 1) ? m1_bmask : m0_bmask;
                if (w == 1) lock = m1_lock;
                gnt_cyc  = cyc + 1;
                done_cyc = cyc + 2;
                next_arb = cyc + 2;
            end else begin
                next_arb = cyc + 1;
            end
        end
        cyc++;
        e_gnt0  = (cyc == gnt_cyc)  && (owner == 0);
        e_gnt1  = (cyc == gnt_cyc)  && (owner == 1);
        e_done0 = (cyc == done_cyc) && (owner == 0);
        e_done1 = (cyc == done_cyc) && (owner == 1);
        e_busy  = (cyc == gnt_cyc) || (cyc == done_cyc);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_bmask = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_bmask = '0; m1_lock = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_req(input int p);
        if (p == 0) begin
            m0_req = 1; m0_we = 1'($urandom_range(0, 1));
            m0_addr = {6'd0, 8'($urandom_range(0, 255)), 2'b00};
            m0_wdata = $urandom; m0_bmask = 4'($urandom_range(0, 15));
        end else begin
            m1_req = 1; m1_we = 1'($urandom_range(0, 1));
            m1_addr = {6'd0, 8'($urandom_range(0, 255)), 2'b00};
            m1_wdata = $urandom; m1_bmask = 4'($urandom_range(0, 15));
            m1_lock = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ram_clear = 1'b1;
        poke_en = 1'b0; poke_idx = '0; poke_data = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b0) begin
            errors++; $display("FAIL reset_gnt_done got %b want 0000", {m0_gnt, m1_gnt, m0_done, m1_done});
        end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_bmask} !== '0) begin
            errors++; $display("FAIL reset_mem got req=%b addr=%h want all zero", mem_req, mem_addr);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (m0_rdata !== mem_rdata || m1_rdata !== mem_rdata) begin
            errors++; $display("FAIL reset_rdata got %h/%h want %h", m0_rdata, m1_rdata, mem_rdata);
        end
        ram_clear = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_port0_read();
        poke_en = 1'b1; poke_idx = 8'd4; poke_data = 32'hDEADBEEF;
        mm[16] = 32'hDEADBEEF;
        tick();
        poke_en = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        tick();
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL rd_gnt got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
            errors++; $display("FAIL rd_mem got req=%b we=%b addr=%h want 1 0 0010", mem_req, mem_we, mem_addr);
        end
        m0_req = 0;
        tick();
        checks++;
        if (m0_done !== 1'b1 || m1_done !== 1'b0) begin
            errors++; $display("FAIL rd_done got m0=%b m1=%b want 1 0", m0_done, m1_done);
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data got %h want deadbeef", m0_rdata);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy got %b want 0", busy); end
    endtask

    // Expects port 0 to have been granted last, so port 1 wins the first contention.
    task automatic test_lock_burst();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0040; m1_lock = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (m0_gnt !== (i == 7) || m1_gnt !== (i == 1 || i == 3 || i == 5)) begin
                errors++; $display("FAIL lock_gnt cyc %0d got m0=%b m1=%b", i, m0_gnt, m1_gnt);
            end
            if (i == 1) begin m1_addr = 16'h0044; m1_lock = 1; end
            if (i == 3) begin m1_addr = 16'h0048; m1_lock = 0; end
            if (i == 5) m1_req = 0;
            if (i == 7) m0_req = 0;
        end
        tick();
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0008;
        m1_req = 1; m1_we = 0; m1_addr = 16'h000C;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (m0_gnt !== (i == 1 || i == 5) || m1_gnt !== (i == 3 || i == 7)) begin
                errors++; $display("FAIL rr_gnt cyc %0d got m0=%b m1=%b", i, m0_gnt, m1_gnt);
            end
            if (i == 7) begin m0_req = 0; m1_req = 0; end
        end
        tick();
    endtask

    task automatic test_write_readback();
        m1_req = 1; m1_we = 1; m1_addr = 16'h0100; m1_wdata = 32'h11223344; m1_bmask = 4'b0011;
        m1_lock = 0;
        tick();
        checks++;
        if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++; $display("FAIL wr_access got gnt=%b we=%b addr=%h", m1_gnt, mem_we, mem_addr);
        end
        checks++;
        if (mem_bmask !== 4'b0011 || mem_wdata !== 32'h11223344) begin
            errors++; $display("FAIL wr_fields got bmask=%b wdata=%h want 0011 11223344", mem_bmask, mem_wdata);
        end
        m1_req = 0; m1_we = 0;
        tick();
        checks++;
        if (m1_done !== 1'b1) begin errors++; $display("FAIL wr_done got %b want 1", m1_done); end
        m0_req = 1; m0_we = 0; m0_addr = 16'h0100;
        tick();
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rb_gnt got gnt=%b we=%b want 1 0", m0_gnt, mem_we);
        end
        m0_req = 0;
        tick();
        checks++;
        if (m0_done !== 1'b1 || m0_rdata !== 32'h00003344) begin
            errors++; $display("FAIL rb_data got done=%b data=%h want 1 00003344", m0_done, m0_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        tick();
        checks++;
        if (m0_gnt !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rma_pre got gnt=%b busy=%b want 1 1", m0_gnt, busy);
        end
        rst = 1'b1;
        m0_req = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || m0_gnt !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rma_async got req=%b gnt=%b busy=%b want 000", mem_req, m0_gnt, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m0_done !== 1'b0 || m1_done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rma_nodone got d0=%b d1=%b busy=%b want 000", m0_done, m1_done, busy);
            end
        end
        m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 16'h0030; m1_lock = 0;
        tick();
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL rma_first got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 0; m1_req = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        bool_loop: for (int n = 0; n < 600; n++) begin
            tick();
            checks++;
            if ({m0_gnt, m1_gnt, m0_done, m1_done} !== {e_gnt0, e_gnt1, e_done0, e_done1}) begin
                errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", cyc,
                    {m0_gnt, m1_gnt, m0_done, m1_done}, {e_gnt0, e_gnt1, e_done0, e_done1});
            end
            checks++;
            if (mem_req !== (e_gnt0 || e_gnt1) || busy !== e_busy) begin
                errors++; $display("FAIL rnd_req cyc %0d got req=%b busy=%b want %b %b", cyc,
                    mem_req, busy, e_gnt0 || e_gnt1, e_busy);
            end
            checks++;
            if (e_gnt0 || e_gnt1) begin
                if ({mem_we, mem_addr, mem_wdata, mem_bmask} !== {t_we, t_addr, t_wdata, t_bmask}) begin
                    errors++; $display("FAIL rnd_bus cyc %0d got %b %h %h %b want %b %h %h %b", cyc,
                        mem_we, mem_addr, mem_wdata, mem_bmask, t_we, t_addr, t_wdata, t_bmask);
                end
            end else if ({mem_we, mem_addr, mem_wdata, mem_bmask} !== '0) begin
                errors++; $display("FAIL rnd_bus_idle cyc %0d got addr=%h want 0", cyc, mem_addr);
            end
            if ((e_done0 || e_done1) && !t_we) begin
                checks++;
                if ((e_done0 ? m0_rdata : m1_rdata) !== exp_rdata) begin
                    errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc,
                        e_done0 ? m0_rdata : m1_rdata, exp_rdata);
                end
            end
            if (m0_req && m0_gnt) begin
                if ($urandom_range(0, 1) == 1) rand_req(0); else m0_req = 0;
            end else if (!m0_req && $urandom_range(0, 9) < 4) begin
                rand_req(0);
            end
            if (m1_req && m1_gnt) begin
                if ($urandom_range(0, 1) == 1) rand_req(1); else m1_req = 0;
            end else if (!m1_req && $urandom_range(0, 9) < 4) begin
                rand_req(1);
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_port0_read();
        test_lock_burst();
        test_contention();
        test_write_readback();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
